// File: rtl/tea_pkg.sv
// tea_pkg: shared types and constants for the TEA CBC controller and core
package tea_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 128;

    localparam logic [31:0] TEA_DELTA = 32'h9E37_79B9;

endpackage

// File: rtl/tea_cbc_chain.sv
// tea_cbc_chain: CBC chain register, IV reload and encrypt/decrypt XOR muxing
module tea_cbc_chain
    import tea_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               load_iv,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [BLOCK_W-1:0] data,
    input  logic               save,
    input  logic               update,
    input  logic [BLOCK_W-1:0] core_out,
    output logic [BLOCK_W-1:0] core_v,
    output logic [BLOCK_W-1:0] result
);

    logic [BLOCK_W-1:0] chain;
    logic [BLOCK_W-1:0] next_chain;

    // chain follows the ciphertext stream; decrypt keeps the incoming ciphertext aside until the core finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain      <= '0;
            next_chain <= '0;
        end else begin
            if (load_iv)
                chain <= iv;
            else if (update)
                chain <= (mode == MODE_DEC) ? next_chain : core_out;
            if (save)
                next_chain <= data;
        end
    end

    assign core_v = (mode == MODE_DEC) ? data : data ^ chain;
    assign result = (mode == MODE_DEC) ? core_out ^ chain : core_out;

endmodule

// File: rtl/tea_cbc_ctrl.sv
// tea_cbc_ctrl: CBC sequencer around an external TEA core; TEA_CBC_TIMEOUT_EN adds a core-done watchdog
module tea_cbc_ctrl
    import tea_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_load,
    input  logic         cfg_mode,
    input  logic [127:0] cfg_key,
    input  logic [63:0]  cfg_iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         core_start,
    output logic         core_mode,
    output logic [31:0]  core_v0,
    output logic [31:0]  core_v1,
    output logic [31:0]  core_k0,
    output logic [31:0]  core_k1,
    output logic [31:0]  core_k2,
    output logic [31:0]  core_k3,
    input  logic         core_done,
    input  logic [31:0]  core_v0_out,
    input  logic [31:0]  core_v1_out,
    output logic         err
);

    state_t             state, state_nx;
    logic               mode;
    logic [KEY_W-1:0]   key;
    logic [BLOCK_W-1:0] iv, data, cv, res;
    logic [BLOCK_W-1:0] chain_v, chain_res;
    logic               last, first;
    logic               cfg_en, in_hs, out_hs, done_ok, tmo;

    assign cfg_en  = cfg_load && state == IDLE;
    assign in_hs   = in_valid && state == IDLE;
    assign out_hs  = out_ready && state == OUT;
    assign done_ok = state == WAIT && !first && core_done;

`ifdef TEA_CBC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    assign tmo = state == WAIT && !done_ok && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign err = err_q;

    // watchdog: count WAIT cycles from zero, latch a sticky error on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state == START) ? '0 : (state == WAIT) ? cnt + 1'b1 : cnt;
            err_q <= cfg_en ? 1'b0 : tmo ? 1'b1 : err_q;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and start pulse
    always_comb begin
        state_nx   = state;
        core_start = 1'b0;
        case (state)
            IDLE:  state_nx = in_hs ? LOAD : IDLE;
            LOAD:  state_nx = START;
            START: begin
                core_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT:  state_nx = done_ok ? OUT : tmo ? IDLE : WAIT;
            OUT:   state_nx = out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    // config, captured block, core operands and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode  <= MODE_ENC;
            key   <= '0;
            iv    <= '0;
            data  <= '0;
            last  <= 1'b0;
            cv    <= '0;
            res   <= '0;
            first <= 1'b0;
        end else begin
            if (cfg_en) begin
                mode <= cfg_mode;
                key  <= cfg_key;
                iv   <= cfg_iv;
            end
            if (in_hs) begin
                data <= in_data;
                last <= in_last;
            end
            if (state == LOAD)
                cv <= chain_v;
            if (done_ok)
                res <= chain_res;
            first <= state == START;
        end
    end

    tea_cbc_chain u_chain (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .load_iv  (cfg_en || (out_hs && last) || tmo),
        .iv       (cfg_en ? cfg_iv : iv),
        .data     (data),
        .save     (state == LOAD),
        .update   (done_ok),
        .core_out ({core_v0_out, core_v1_out}),
        .core_v   (chain_v),
        .result   (chain_res)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;
    assign out_data  = res;
    assign out_last  = last;
    assign core_mode = mode;
    assign {core_k0, core_k1, core_k2, core_k3} = key;
    assign {core_v0, core_v1} = cv;

endmodule

// File: tb/tb_tea_cbc_ctrl.sv
// tb_tea_cbc_ctrl: randomized CBC checks against a TEA/CBC reference model with a behavioural core
module tb_tea_cbc_ctrl;
    import tea_pkg::*;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         cfg_load = 1'b0, cfg_mode = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [63:0]  cfg_iv = '0, in_data = '0, out_data;
    logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic         out_valid, out_ready = 1'b0, out_last, busy, core_start, core_mode, core_done, err;
    logic [31:0]  core_v0, core_v1, core_k0, core_k1, core_k2, core_k3, core_v0_out, core_v1_out;

    int n_cmp = 0, n_err = 0;

    tea_cbc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .core_start(core_start), .core_mode(core_mode),
        .core_v0(core_v0), .core_v1(core_v1), .core_k0(core_k0), .core_k1(core_k1),
        .core_k2(core_k2), .core_k3(core_k3), .core_done(core_done),
        .core_v0_out(core_v0_out), .core_v1_out(core_v1_out), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tea_enc(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y = v[63:32], z = v[31:0], s = 32'd0;
        for (int r = 0; r < 32; r++) begin
            s += TEA_DELTA;
            y += ((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]);
            z += ((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]);
        end
        return {y, z};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y = v[63:32], z = v[31:0], s = TEA_DELTA * 32;
        for (int r = 0; r < 32; r++) begin
            z -= ((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]);
            y -= ((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]);
            s -= TEA_DELTA;
        end
        return {y, z};
    endfunction

    // behavioural core: done pulses on the lat-th WAIT cycle, optionally a stale pulse on the first
    int          lat = 4, n_start = 0, ccnt = 0;
    bit          stale = 0, cbusy = 0;
    logic [63:0] cres = '0, cin = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbusy <= 0;
            ccnt  <= 0;
        end else if (core_start) begin
            cbusy <= 1;
            ccnt  <= 1;
            cin   <= {core_v0, core_v1};
            cres  <= core_mode ? tea_dec({core_v0, core_v1}, {core_k0, core_k1, core_k2, core_k3})
                               : tea_enc({core_v0, core_v1}, {core_k0, core_k1, core_k2, core_k3});
        end else if (cbusy) begin
            if (ccnt == lat) cbusy <= 0;
            ccnt <= ccnt + 1;
        end
    end

    always @(posedge clk) if (core_start) n_start <= n_start + 1;

    assign core_done = cbusy && (ccnt == lat || (stale && ccnt == 1));
    assign {core_v0_out, core_v1_out} = cres;

    // CBC reference model
    bit           m_mode = 0;
    logic [127:0] m_key = '0;
    logic [63:0]  m_iv = '0, m_chain = '0;

    function automatic logic [63:0] model_block(input logic [63:0] d, input bit l);
        logic [63:0] r;
        if (m_mode) begin
            r = tea_dec(d, m_key) ^ m_chain;
            m_chain = d;
        end else begin
            r = tea_enc(d ^ m_chain, m_key);
            m_chain = r;
        end
        if (l) m_chain = m_iv;
        return r;
    endfunction

    task automatic cfg(input bit md, input logic [127:0] k, input logic [63:0] v);
        cfg_load = 1; cfg_mode = md; cfg_key = k; cfg_iv = v;
        @(negedge clk);
        cfg_load = 0;
        m_mode = md; m_key = k; m_iv = v; m_chain = v;
    endtask

    task automatic xfer(input logic [63:0] d, input bit l, input int stall,
                        output logic [63:0] got, output bit gl, output bit ok);
        int t = 0;
        ok = 0; got = '0; gl = 0;
        in_valid = 1; in_data = d; in_last = l;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < 500; i++) begin
            out_ready = (stall == 0) || ($urandom_range(0, stall) == 0);
            if (out_valid && out_ready) begin
                got = out_data; gl = out_last; ok = 1;
                @(negedge clk);
                out_ready = 0;
                break;
            end
            @(negedge clk);
        end
        out_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, core_start, core_mode, err, out_last} !== 6'b0 || out_data !== 64'h0 ||
            {core_v0, core_v1, core_k0, core_k1, core_k2, core_k3} !== 192'h0) begin
            n_err++;
            $display("FAIL reset_outputs: ov=%b busy=%b st=%b mode=%b err=%b od=%h, required all zero",
                     out_valid, busy, core_start, core_mode, err, out_data);
        end
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
    endtask

    task automatic check_blk(input string nm, input logic [63:0] got, input bit ok, input logic [63:0] exp);
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h (valid=%b), required %h", nm, got, ok, exp);
        end
    endtask

    task automatic test_vectors;
        logic [63:0] g, ct = 64'h41EA3A0A_94BAA940;
        bit gl, ok;
        lat = 4; stale = 0;
        cfg(MODE_ENC, '0, '0);
        xfer(64'h0, 0, 0, g, gl, ok);
        n_cmp++;
        if (!ok || g !== ct) begin n_err++; $display("FAIL vec_enc0: got %h, required %h", g, ct); end
        xfer(ct, 1, 0, g, gl, ok);
        n_cmp++;
        if (cin !== 64'h0) begin n_err++; $display("FAIL vec_core_v: got %h, required 0", cin); end
        n_cmp++;
        if (!ok || g !== ct || gl !== 1'b1) begin n_err++; $display("FAIL vec_enc1: got %h last=%b, required %h last=1", g, gl, ct); end
        xfer(64'h0, 1, 0, g, gl, ok);
        n_cmp++;
        if (!ok || g !== ct) begin n_err++; $display("FAIL vec_iv_reload: got %h, required %h", g, ct); end
        cfg(MODE_DEC, '0, '0);
        xfer(ct, 0, 1, g, gl, ok);
        n_cmp++;
        if (!ok || g !== 64'h0 || gl !== 1'b0) begin n_err++; $display("FAIL vec_dec0: got %h, required 0", g); end
        xfer(ct, 1, 1, g, gl, ok);
        n_cmp++;
        if (!ok || g !== ct) begin n_err++; $display("FAIL vec_dec1: got %h, required %h", g, ct); end
    endtask

    task automatic test_random;
        logic [63:0] g, d, e;
        bit gl, ok, l;
        int len;
        for (int m = 0; m < 8; m++) begin
            cfg(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                lat = $urandom_range(2, 40);
                d = {$urandom, $urandom};
                l = (b == len - 1);
                e = model_block(d, l);
                xfer(d, l, $urandom_range(0, 3), g, gl, ok);
                n_cmp++;
                if (!ok || g !== e || gl !== l) begin
                    n_err++;
                    $display("FAIL random m%0d b%0d: got %h last=%b, required %h last=%b", m, b, g, gl, e, l);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [63:0] e, held;
        int s0, t = 0;
        bit bad = 0;
        lat = 5;
        cfg(MODE_ENC, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        e = model_block(64'h0123_4567_89AB_CDEF, 1);
        in_valid = 1; in_data = 64'h0123_4567_89AB_CDEF; in_last = 1;
        @(negedge clk);
        in_valid = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        held = out_data; s0 = n_start;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== held || in_ready !== 1'b0 || n_start != s0) bad = 1;
        end
        n_cmp++;
        if (bad) begin n_err++; $display("FAIL stall_hold: od=%h ov=%b ir=%b starts=%0d, required %h 1 0 %0d", out_data, out_valid, in_ready, n_start, held, s0); end
        n_cmp++;
        if (held !== e) begin n_err++; $display("FAIL stall_data: got %h, required %h", held, e); end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: ov=%b ir=%b, required 0/1", out_valid, in_ready); end
    endtask

    task automatic test_stale;
        logic [63:0] e;
        int s0, c = 0;
        stale = 1; lat = 32;
        cfg(MODE_ENC, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        e = model_block(64'hDEAD_BEEF_0000_0001, 0);
        s0 = n_start;
        in_valid = 1; in_data = 64'hDEAD_BEEF_0000_0001; in_last = 0;
        @(negedge clk); c = 1;
        in_valid = 0;
        while (!out_valid && c < 100) begin @(negedge clk); c++; end
        n_cmp++;
        if (c != 35) begin n_err++; $display("FAIL stale_latency: got %0d cycles, required 35", c); end
        n_cmp++;
        if (out_data !== e) begin n_err++; $display("FAIL stale_data: got %h, required %h", out_data, e); end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_start - s0 != 1 || busy !== 1'b0) begin n_err++; $display("FAIL stale_starts: got %0d busy=%b, required 1 busy=0", n_start - s0, busy); end
        stale = 0;
    endtask

    task automatic test_abort;
        logic [63:0] g;
        bit gl, ok;
        lat = 0;
        cfg(MODE_DEC, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        in_valid = 1; in_data = {$urandom, $urandom}; in_last = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, core_start, core_mode, err} !== 5'b0 || {core_v0, core_v1, core_k0} !== 96'h0) begin
            n_err++;
            $display("FAIL abort_outputs: ov=%b busy=%b mode=%b v=%h%h, required zero", out_valid, busy, core_mode, core_v0, core_v1);
        end
        rst_n = 1;
        m_mode = 0; m_key = '0; m_iv = '0; m_chain = '0;
        lat = 3;
        @(negedge clk);
        xfer(64'h0, 0, 0, g, gl, ok);
        check_blk("abort_chain_zero", g, ok, 64'h41EA3A0A_94BAA940);
    endtask

`ifdef TEA_CBC_TIMEOUT_EN
    task automatic test_timeout;
        logic [63:0] g, e;
        bit gl, ok, seen = 0;
        int c = 1;
        lat = 0;
        cfg(MODE_ENC, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        in_valid = 1; in_data = {$urandom, $urandom}; in_last = 0;
        @(negedge clk);
        in_valid = 0;
        while (busy && c < 100) begin if (out_valid) seen = 1; @(negedge clk); c++; end
        n_cmp++;
        if (c != 19 || err !== 1'b1 || seen || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL timeout: cycles=%0d err=%b ov_seen=%b ir=%b, required 19 1 0 1", c, err, seen, in_ready);
        end
        lat = 4;
        e = model_block(64'h5555_AAAA_1234_5678, 0);
        xfer(64'h5555_AAAA_1234_5678, 0, 0, g, gl, ok);
        check_blk("timeout_iv_reload", g, ok, e);
        cfg(MODE_ENC, '0, '0);
        n_cmp++;
        if (err !== 1'b0) begin n_err++; $display("FAIL timeout_err_clear: got %b, required 0", err); end
    endtask
`endif

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_stall;
        test_stale;
        test_abort;
`ifdef TEA_CBC_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
